// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, handshake
// levels, datapath widths and small arithmetic helpers.
package div_unit_pkg;

   localparam int REG_WIDTH        = 32;
   localparam int DOUBLE_REG_WIDTH = 64;
   localparam int WORK_WIDTH       = 65;
   localparam int CNT_WIDTH        = 6;

   localparam logic [CNT_WIDTH-1:0] DIV_LAST_STEP = 6'd32;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   // Two's-complement negation of a word.
   function automatic logic [REG_WIDTH-1:0] neg32(input logic [REG_WIDTH-1:0] value);
      neg32 = (~value) + 32'd1;
   endfunction

   // Magnitude of an operand when it is to be treated as signed.
   function automatic logic [REG_WIDTH-1:0] mag32(input logic                 is_signed,
                                                  input logic [REG_WIDTH-1:0] value);
      if (is_signed && value[REG_WIDTH-1]) begin
         mag32 = neg32(value);
      end else begin
         mag32 = value;
      end
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU): one quotient bit per clock,
// result presented as {remainder, quotient} with a ready/start handshake.
module div_unit
   import div_unit_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        signed_div_i,
   input  logic [REG_WIDTH-1:0]        opdata1_i,
   input  logic [REG_WIDTH-1:0]        opdata2_i,
   input  logic                        start_i,
   input  logic                        annul_i,
   output logic [DOUBLE_REG_WIDTH-1:0] result_o,
   output logic                        ready_o
);

   div_state_e                  state_r;
   div_state_e                  state_next_s;
   logic [CNT_WIDTH-1:0]        cnt_r;
   logic [CNT_WIDTH-1:0]        cnt_next_s;
   logic [WORK_WIDTH-1:0]       work_r;
   logic [WORK_WIDTH-1:0]       work_next_s;
   logic [REG_WIDTH-1:0]        divisor_r;
   logic [REG_WIDTH-1:0]        divisor_next_s;
   logic                        dividend_neg_r;
   logic                        dividend_neg_next_s;
   logic                        divisor_neg_r;
   logic                        divisor_neg_next_s;
   logic [DOUBLE_REG_WIDTH-1:0] result_r;
   logic [DOUBLE_REG_WIDTH-1:0] result_next_s;
   logic                        ready_r;
   logic                        ready_next_s;

   logic                        accept_s;
   logic [REG_WIDTH:0]          trial_s;
   logic [REG_WIDTH-1:0]        quot_s;
   logic [REG_WIDTH-1:0]        rem_s;

   assign accept_s = (start_i == DIV_START) && (annul_i == 1'b0);

   // Partial remainder sits in work_r[63:32]; bit 32 of the trial is the borrow.
   assign trial_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};
   assign quot_s  = work_r[31:0];
   assign rem_s   = work_r[64:33];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DIV_FREE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         DIV_FREE: begin
            if (accept_s) begin
               if (opdata2_i == 32'd0) begin
                  state_next_s = DIV_BYZERO;
               end else begin
                  state_next_s = DIV_ON;
               end
            end else begin
               state_next_s = DIV_FREE;
            end
         end
         DIV_BYZERO: begin
            if (annul_i) begin
               state_next_s = DIV_FREE;
            end else begin
               state_next_s = DIV_END;
            end
         end
         DIV_ON: begin
            if (annul_i) begin
               state_next_s = DIV_FREE;
            end else if (cnt_r == DIV_LAST_STEP) begin
               state_next_s = DIV_END;
            end else begin
               state_next_s = DIV_ON;
            end
         end
         DIV_END: begin
            if (start_i == DIV_STOP) begin
               state_next_s = DIV_FREE;
            end else begin
               state_next_s = DIV_END;
            end
         end
         default: begin
            state_next_s = DIV_FREE;
         end
      endcase
   end

   // Datapath and output next-value decode.
   always_comb begin
      cnt_next_s          = cnt_r;
      work_next_s         = work_r;
      divisor_next_s      = divisor_r;
      dividend_neg_next_s = dividend_neg_r;
      divisor_neg_next_s  = divisor_neg_r;
      result_next_s       = result_r;
      ready_next_s        = ready_r;
      case (state_r)
         DIV_FREE: begin
            result_next_s = 64'd0;
            ready_next_s  = DIV_RESULT_NOT_READY;
            if (accept_s && (opdata2_i != 32'd0)) begin
               cnt_next_s          = 6'd0;
               divisor_next_s      = mag32(signed_div_i, opdata2_i);
               work_next_s         = {32'd0, mag32(signed_div_i, opdata1_i), 1'b0};
               dividend_neg_next_s = signed_div_i & opdata1_i[31];
               divisor_neg_next_s  = signed_div_i & opdata2_i[31];
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         DIV_BYZERO: begin
            result_next_s = 64'd0;
            if (annul_i) begin
               ready_next_s = DIV_RESULT_NOT_READY;
            end else begin
               ready_next_s = DIV_RESULT_READY;
            end
         end
         DIV_ON: begin
            if (annul_i) begin
               cnt_next_s    = 6'd0;
               result_next_s = 64'd0;
               ready_next_s  = DIV_RESULT_NOT_READY;
            end else if (cnt_r == DIV_LAST_STEP) begin
               // Sign fix-up: quotient follows the XOR of signs, remainder the dividend.
               result_next_s[31:0]  = (dividend_neg_r ^ divisor_neg_r) ? neg32(quot_s) : quot_s;
               result_next_s[63:32] = dividend_neg_r ? neg32(rem_s) : rem_s;
               ready_next_s         = DIV_RESULT_READY;
            end else begin
               if (trial_s[REG_WIDTH]) begin
                  work_next_s = {work_r[63:0], 1'b0};
               end else begin
                  work_next_s = {trial_s[31:0], work_r[31:0], 1'b1};
               end
               cnt_next_s = cnt_r + 6'd1;
            end
         end
         DIV_END: begin
            if (start_i == DIV_STOP) begin
               result_next_s = 64'd0;
               ready_next_s  = DIV_RESULT_NOT_READY;
            end else begin
               ready_next_s = ready_r;
            end
         end
         default: begin
            result_next_s = 64'd0;
            ready_next_s  = DIV_RESULT_NOT_READY;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r          <= 6'd0;
         work_r         <= 65'd0;
         divisor_r      <= 32'd0;
         dividend_neg_r <= 1'b0;
         divisor_neg_r  <= 1'b0;
         result_r       <= 64'd0;
         ready_r        <= DIV_RESULT_NOT_READY;
      end else begin
         cnt_r          <= cnt_next_s;
         work_r         <= work_next_s;
         divisor_r      <= divisor_next_s;
         dividend_neg_r <= dividend_neg_next_s;
         divisor_neg_r  <= divisor_neg_next_s;
         result_r       <= result_next_s;
         ready_r        <= ready_next_s;
      end
   end

   assign result_o = result_r;
   assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, hold/release,
// abort and reset behaviour against hand-computed expectations.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int errors;
   int checks;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Full handshake: start, count edges to ready, hold one edge, then release.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
      int edges;
      logic got;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      edges        = 0;
      got          = 1'b0;
      while (!got && edges < 100) begin
         tick();
         edges++;
         if (edges == 1) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sgn;
         end
         got = ready_o;
      end
      check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
      check({tag, "_result"}, result_o, exp);
      tick();
      check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({tag, "_hold_result"}, result_o, exp);
      start_i = 1'b0;
      tick();
      check({tag, "_rel_ready"}, {63'd0, ready_o}, 64'd0);
      check({tag, "_rel_result"}, result_o, 64'd0);
   endtask

   initial begin
      logic saw;
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      @(negedge clk);
      tick();
      tick();
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      rst = 1'b0;
      tick();

      run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
      run_div("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
      run_div("udiv_big_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);
      run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
      run_div("div_by_zero", 1'b0, 32'd5, 32'd0, 64'd0, 2);

      // Abort: annul pulsed on edge 10, start dropped with it.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      saw          = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         saw = saw | ready_o;
      end
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         saw = saw | ready_o;
         tick();
      end
      check("abort_no_ready", {63'd0, saw}, 64'd0);
      run_div("udiv_ffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);

      run_div("sdiv_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);

      // Reset on edge 20 with start still held; start kept high across a second rst edge.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      for (int i = 1; i <= 19; i++) begin
         tick();
      end
      rst = 1'b1;
      tick();
      check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      tick();
      rst     = 1'b0;
      start_i = 1'b0;
      saw     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         saw = saw | ready_o;
      end
      check("rst_no_ready", {63'd0, saw}, 64'd0);
      run_div("udiv_1000_10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 34);
      run_div("udiv_ffff_16", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
